// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  typedef logic [31:0] DATA_BUS;
  typedef logic [3:0]  BYTE_EN;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_D  = 3'd2,
    ERR_IF  = 3'd3,
    ERR_D   = 3'd4
  } arb_state_t;

  localparam BYTE_EN FULL_WORD_BE = 4'b1111;

  // Word accesses only: the two low address bits must be clear.
  function automatic logic is_aligned(input DATA_BUS addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle timer: reads 1 in the first busy cycle and flags the TIMEOUT-th one.
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  logic [TW-1:0] cnt;

  // Preload 1 while idle so the count equals the busy-cycle index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= TW'(1);
    else if (run)
      cnt <= cnt + TW'(1);
  end

  // Expiry is only meaningful while a transaction is outstanding.
  always_comb begin
    expired = run && (cnt == TW'(TIMEOUT));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// load/store. Data wins by default; a streak counter forces a fetch grant
// after MAX_D_STREAK consecutive data grants while fetch is waiting.
//
// state   | meaning
// IDLE    | no transaction; grant decision taken at the clock edge
// BUSY_IF | fetch access on the memory port, waiting for mem_ack
// BUSY_D  | data access on the memory port, waiting for mem_ack
// ERR_IF  | misaligned fetch rejected; if_err high this cycle
// ERR_D   | misaligned data access rejected; d_err high this cycle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255,
  parameter int TW           = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    if_req,
  input  DATA_BUS if_addr,
  output logic    if_ack,
  output DATA_BUS if_rdata,
  output logic    if_err,
  input  logic    d_req,
  input  logic    d_we,
  input  BYTE_EN  d_be,
  input  DATA_BUS d_addr,
  input  DATA_BUS d_wdata,
  output logic    d_ack,
  output DATA_BUS d_rdata,
  output logic    d_err,
  output logic    mem_req,
  output logic    mem_we,
  output BYTE_EN  mem_be,
  output DATA_BUS mem_addr,
  output DATA_BUS mem_wdata,
  input  logic    mem_ack,
  input  DATA_BUS mem_rdata,
  output logic    busy
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic          if_err_q, d_err_q;
  logic          in_busy, expired;
  logic          eff_if, eff_d, streak_full;
  logic          grant_if, grant_d;

  // A timed-out requester still holds req during its err cycle; mask it so
  // the same request is not granted again before it sees the error.
  always_comb begin
    eff_if      = if_req & ~if_err_q;
    eff_d       = d_req & ~d_err_q;
    streak_full = (streak == SW'(MAX_D_STREAK));
  end

  // Grant decision, only taken in IDLE.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state == IDLE) begin
      if (eff_d && !(eff_if && streak_full))
        grant_d = 1'b1;
      else if (eff_if)
        grant_if = 1'b1;
    end
  end

  always_comb begin
    in_busy = (state == BUSY_IF) || (state == BUSY_D);
  end

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (in_busy),
    .clear   (!in_busy),
    .expired (expired)
  );

  // State, streak, launch registers and registered error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_err_q  <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            if (if_req && !streak_full)
              streak <= streak + SW'(1);
            if (is_aligned(d_addr)) begin
              state     <= BUSY_D;
              mem_we    <= d_we;
              mem_be    <= d_be;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state   <= ERR_D;
              d_err_q <= 1'b1;
            end
          end else if (grant_if) begin
            streak <= '0;
            if (is_aligned(if_addr)) begin
              state     <= BUSY_IF;
              mem_we    <= 1'b0;
              mem_be    <= FULL_WORD_BE;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end else begin
              state    <= ERR_IF;
              if_err_q <= 1'b1;
            end
          end
        end
        BUSY_IF: begin
          if (mem_ack)
            state <= IDLE;
          else if (expired) begin
            state    <= IDLE;
            if_err_q <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ack)
            state <= IDLE;
          else if (expired) begin
            state   <= IDLE;
            d_err_q <= 1'b1;
          end
        end
        ERR_IF:  state <= IDLE;
        ERR_D:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Requester-side responses; completion is passed through in the ack cycle.
  always_comb begin
    mem_req  = in_busy;
    busy     = (state != IDLE);
    if_ack   = (state == BUSY_IF) && mem_ack;
    d_ack    = (state == BUSY_D) && mem_ack;
    if_err   = if_err_q;
    d_err    = d_err_q;
    if_rdata = if_ack ? mem_rdata : '0;
    d_rdata  = (d_ack && !mem_we) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=8, MAX_D_STREAK=4.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    if_req;
  DATA_BUS if_addr;
  logic    if_ack;
  DATA_BUS if_rdata;
  logic    if_err;
  logic    d_req;
  logic    d_we;
  BYTE_EN  d_be;
  DATA_BUS d_addr;
  DATA_BUS d_wdata;
  logic    d_ack;
  DATA_BUS d_rdata;
  logic    d_err;
  logic    mem_req;
  logic    mem_we;
  BYTE_EN  mem_be;
  DATA_BUS mem_addr;
  DATA_BUS mem_wdata;
  logic    mem_ack;
  DATA_BUS mem_rdata;
  logic    busy;

  int errors = 0;
  int checks = 0;

  localparam DATA_BUS IF_A = 32'h0000_0400;
  localparam DATA_BUS D_A  = 32'h0000_2008;

  mem_port_arbiter #(
    .MAX_D_STREAK (4),
    .TIMEOUT      (8),
    .TW           (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One contended grant: busy cycle 1 shows the winner, ack in busy cycle 2.
  task automatic grant_step(input logic exp_if, input int idx);
    tick();
    chk($sformatf("grant%0d_addr", idx), mem_addr, exp_if ? IF_A : D_A);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h1000 + idx;
    #1;
    if (exp_if) chk($sformatf("grant%0d_if_ack", idx), {31'b0, if_ack}, 32'd1);
    else        chk($sformatf("grant%0d_d_ack", idx), {31'b0, d_ack}, 32'd1);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0;
    d_addr = '0; d_wdata = '0; mem_ack = 0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_errs", {30'b0, if_err, d_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Single fetch, ack in busy cycle 3
    if_req = 1; if_addr = 32'h100;
    tick();
    chk("f_mem_req1", {31'b0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_be", {28'b0, mem_be}, 32'hF);
    chk("f_mem_we", {31'b0, mem_we}, 32'd0);
    chk("f_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("f_mem_req2", {31'b0, mem_req}, 32'd1);
    chk("f_no_ack2", {31'b0, if_ack}, 32'd0);
    tick();
    mem_ack = 1; mem_rdata = 32'h0050_0093;
    #1;
    chk("f_mem_req3", {31'b0, mem_req}, 32'd1);
    chk("f_if_ack", {31'b0, if_ack}, 32'd1);
    chk("f_if_rdata", if_rdata, 32'h0050_0093);
    chk("f_d_ack", {31'b0, d_ack}, 32'd0);
    if_req = 0;
    tick();
    mem_ack = 0; mem_rdata = '0;
    #1;
    chk("f_busy_after", {31'b0, busy}, 32'd0);
    chk("f_mem_req_after", {31'b0, mem_req}, 32'd0);

    // Data write
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
    tick();
    chk("w_mem_we", {31'b0, mem_we}, 32'd1);
    chk("w_mem_be", {28'b0, mem_be}, 32'h3);
    chk("w_mem_addr", mem_addr, 32'h2004);
    chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    #1;
    chk("w_d_ack", {31'b0, d_ack}, 32'd1);
    chk("w_d_rdata", d_rdata, 32'd0);
    chk("w_if_ack", {31'b0, if_ack}, 32'd0);
    d_req = 0;
    tick();
    mem_ack = 0; mem_rdata = '0;
    #1;
    chk("w_busy_after", {31'b0, busy}, 32'd0);

    // Misaligned data read
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h2002;
    tick();
    chk("m_d_err", {31'b0, d_err}, 32'd1);
    chk("m_mem_req", {31'b0, mem_req}, 32'd0);
    chk("m_busy", {31'b0, busy}, 32'd1);
    d_req = 0;
    tick();
    chk("m_d_err_off", {31'b0, d_err}, 32'd0);
    chk("m_mem_req_after", {31'b0, mem_req}, 32'd0);
    chk("m_busy_after", {31'b0, busy}, 32'd0);

    // Timeout, no ack
    if_req = 1; if_addr = 32'h200;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t_mem_req_c%0d", i), {31'b0, mem_req}, 32'd1);
      chk($sformatf("t_no_err_c%0d", i), {31'b0, if_err}, 32'd0);
    end
    tick();
    chk("t_mem_req_off", {31'b0, mem_req}, 32'd0);
    chk("t_if_err", {31'b0, if_err}, 32'd1);
    chk("t_busy_off", {31'b0, busy}, 32'd0);
    if_req = 0;
    tick();
    chk("t_if_err_off", {31'b0, if_err}, 32'd0);
    chk("t_no_regrant", {31'b0, busy}, 32'd0);
    tick();
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("late_acks", {30'b0, if_ack, d_ack}, 32'd0);
    chk("late_if_rdata", if_rdata, 32'd0);
    chk("late_d_rdata", d_rdata, 32'd0);
    chk("late_errs", {30'b0, if_err, d_err}, 32'd0);
    tick();
    mem_ack = 0; mem_rdata = '0;

    // Ack in the final busy cycle wins over the timeout
    if_req = 1; if_addr = 32'h300;
    for (int i = 1; i <= 7; i++) tick();
    tick();
    mem_ack = 1; mem_rdata = 32'hCAFE_0001;
    #1;
    chk("t8_if_ack", {31'b0, if_ack}, 32'd1);
    chk("t8_if_rdata", if_rdata, 32'hCAFE_0001);
    chk("t8_no_err", {31'b0, if_err}, 32'd0);
    if_req = 0;
    tick();
    mem_ack = 0; mem_rdata = '0;
    #1;
    chk("t8_no_err_next", {31'b0, if_err}, 32'd0);
    chk("t8_busy_after", {31'b0, busy}, 32'd0);

    // Contention: D,D,D,D,IF,D,D,D,D,IF
    if_req = 1; if_addr = IF_A; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = D_A; d_wdata = '0;
    for (int i = 0; i < 10; i++) grant_step((i == 4) || (i == 9), i);

    // Reset during busy cycle 2 of a data grant (streak becomes 1 first)
    tick();
    chk("r_pre_addr", mem_addr, D_A);
    tick();
    rst = 1;
    #1;
    chk("r_mem_req", {31'b0, mem_req}, 32'd0);
    chk("r_busy", {31'b0, busy}, 32'd0);
    chk("r_outs", {28'b0, if_ack, if_err, d_ack, d_err}, 32'd0);
    tick();
    chk("r_hold_outs", {27'b0, mem_req, if_ack, if_err, d_ack, d_err}, 32'd0);
    rst = 0;
    // Streak must restart from 0: fetch wins on the fifth grant, not the fourth
    for (int i = 0; i < 5; i++) grant_step(i == 4, 20 + i);
    if_req = 0; d_req = 0;
    tick();
    chk("end_busy", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
